// File: rtl/tetris_pkg.sv
// Shared tetromino definitions: piece codes, type count, reserved "no piece" code.
// Pure declarations, no latency.
// No flow control here; users decide how codes move.
package tetris_pkg;

  typedef enum logic [2:0] {
    I = 3'd0,
    O = 3'd1,
    T = 3'd2,
    S = 3'd3,
    Z = 3'd4,
    J = 3'd5,
    L = 3'd6
  } piece_t;

  localparam int         NUM_PIECE_TYPES = 7;
  localparam logic [2:0] PIECE_NONE      = 3'b111;
  localparam logic [6:0] BAG_FULL        = 7'h7F;

  // Raw 3-bit random value to scan start index; the reserved code folds onto piece 0.
  function automatic logic [2:0] start_index(input logic [2:0] r);
    return (r == PIECE_NONE) ? 3'd0 : r;
  endfunction

endpackage

// File: rtl/lfsr.sv
// 15-bit Fibonacci LFSR (x^15 + x^14 + 1), exposes its low 3 bits as a random value.
// Advances on every clock edge; value reflects the current register state.
// No backpressure: free-running, the consumer samples whenever it needs a value.
module lfsr #(
  parameter logic [14:0] SEED = 15'h6A5
) (
  input  logic       clk,
  input  logic       nreset,
  output logic [2:0] rnd
);

  logic [14:0] state;

  assign rnd = state[2:0];

  // Shift left, feeding back the XOR of the two top taps.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state <= SEED;
    end else begin
      state <= {state[13:0], state[14] ^ state[13]};
    end
  end

endmodule

// File: rtl/piecebag.sv
// Tetromino stream generator with preview queue of PREVIEW_DEPTH+1 entries;
// optional 7-bag randomiser under macro PIECEBAG_BAG_EN (else plain random).
// Push visible one edge later; pop-to-next-head is 0 cycles; take ignored when empty.
module piecebag
  import tetris_pkg::*;
#(
  parameter int          PREVIEW_DEPTH = 3,
  parameter logic [14:0] SEED          = 15'h6A5
) (
  input  logic                         clk,
  input  logic                         nreset,
  input  logic                         take,
  output logic                         valid,
  output logic [2:0]                   piece,
  output logic [PREVIEW_DEPTH*3-1:0]   preview,
  output logic [PREVIEW_DEPTH-1:0]     preview_valid
);

  localparam int D  = PREVIEW_DEPTH + 1;
  localparam int AW = $clog2(D);

  logic [2:0]    rnd;
  logic [2:0]    start;
  piece_t        sel;

  // Queue kept as a head-aligned shift register with a thermometer valid mask,
  // so every output is a flop and vacated slots are zeroed.
  logic [2:0]    q      [D];
  logic [2:0]    q_nxt  [D];
  logic [D-1:0]  qv;
  logic [D-1:0]  qv_nxt;
  logic [AW-1:0] wr;
  logic          pop;
  logic          push;

  lfsr #(.SEED(SEED)) u_lfsr (
    .clk    (clk),
    .nreset (nreset),
    .rnd    (rnd)
  );

  assign start = start_index(rnd);
  assign pop   = take & qv[0];
  // When full a slot only frees up through a same-cycle pop.
  assign push  = ~qv[D-1] | pop;

`ifdef PIECEBAG_BAG_EN
  logic [6:0] used;
  logic [6:0] used_nxt;
  logic [3:0] sum;
  logic [2:0] cand;
  logic       found;

  // Pick the first piece not yet dealt in this bag, scanning upward from start.
  always_comb begin
    sel   = piece_t'(start);
    found = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int k = 0; k < NUM_PIECE_TYPES; k++) begin
      sum  = {1'b0, start} + 4'(k);
      cand = (sum >= 4'd7) ? 3'(sum - 4'd7) : sum[2:0];
      if (!found && !used[cand]) begin
        sel   = piece_t'(cand);
        found = 1'b1;
      end
    end
    used_nxt = used | (7'b1 << sel);
    if (used_nxt == BAG_FULL) begin
      used_nxt = '0;
    end
  end

  // Bag mask tracks pieces already dealt; it clears as the last one is dealt.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      used <= '0;
    end else if (push) begin
      used <= used_nxt;
    end
  end
`else
  assign sel = piece_t'(start);
`endif

  // Next queue state: shift on pop, then append at the first free slot.
  always_comb begin
    q_nxt  = q;
    qv_nxt = qv;
    wr     = '0;
    if (pop) begin
      for (int i = 0; i < D-1; i++) begin
        q_nxt[i] = q[i+1];
      end
      q_nxt[D-1] = '0;
      qv_nxt     = {1'b0, qv[D-1:1]};
    end
    for (int i = D-1; i >= 0; i--) begin
      if (!qv_nxt[i]) begin
        wr = AW'(i);
      end
    end
    if (push) begin
      q_nxt[wr]  = sel;
      qv_nxt[wr] = 1'b1;
    end
  end

  // Queue storage.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      qv <= '0;
      q  <= '{default: '0};
    end else begin
      qv <= qv_nxt;
      q  <= q_nxt;
    end
  end

  assign valid         = qv[0];
  assign piece         = q[0];
  assign preview_valid = qv[D-1:1];

  for (genvar i = 0; i < PREVIEW_DEPTH; i++) begin : g_preview
    assign preview[3*i +: 3] = q[i+1];
  end

endmodule

// File: tb/tb_piecebag.sv
// Self-checking bench for piecebag: depth-3 and depth-1 instances share clock,
// reset and take; a scoreboard queue per instance holds pieces expected in order.
// Respects PIECEBAG_BAG_EN the same way the design does.
module tb_piecebag;

  logic       clk = 1'b0;
  logic       nreset;
  logic       take;

  logic       valid0;
  logic [2:0] piece0;
  logic [8:0] preview0;
  logic [2:0] pv0;

  logic       valid1;
  logic [2:0] piece1;
  logic [2:0] preview1;
  logic [0:0] pv1;

  always #5 clk = ~clk;

  piecebag #(.PREVIEW_DEPTH(3), .SEED(15'h6A5)) dut0 (
    .clk           (clk),
    .nreset        (nreset),
    .take          (take),
    .valid         (valid0),
    .piece         (piece0),
    .preview       (preview0),
    .preview_valid (pv0)
  );

  piecebag #(.PREVIEW_DEPTH(1), .SEED(15'h6A5)) dut1 (
    .clk           (clk),
    .nreset        (nreset),
    .take          (take),
    .valid         (valid1),
    .piece         (piece1),
    .preview       (preview1),
    .preview_valid (pv1)
  );

  typedef logic [2:0] pq_t[$];

  pq_t         eq0;
  pq_t         eq1;
  logic [14:0] mlfsr;
  logic [6:0]  mused0;
  logic [6:0]  mused1;
  int          pop_cnt;
  logic [6:0]  bag_seen;
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference piece choice from the reference LFSR value and bag mask.
  function automatic logic [2:0] pick(input logic [14:0] l, input logic [6:0] used);
    int s;
    int c;
    s = (l[2:0] == 3'd7) ? 0 : int'(l[2:0]);
`ifdef PIECEBAG_BAG_EN
    c = s;
    repeat (7) begin
      if (!used[c]) return 3'(c);
      c = (c + 1) % 7;
    end
    return 3'd7;
`else
    c = int'(used[0]);
    return 3'(s);
`endif
  endfunction

  function automatic logic [6:0] mark(input logic [6:0] used, input logic [2:0] p);
    logic [6:0] m;
    m = used | (7'b1 << p);
    return (m == 7'h7F) ? 7'h00 : m;
  endfunction

  task automatic model_reset();
    eq0.delete();
    eq1.delete();
    mlfsr    = 15'h6A5;
    mused0   = '0;
    mused1   = '0;
    pop_cnt  = 0;
    bag_seen = '0;
  endtask

  // Advance one instance's reference by one edge; a pop compares the DUT head
  // against the front of the scoreboard before the edge removes it.
  task automatic model_inst(input int n, input logic tk);
    pq_t        q;
    logic [6:0] u;
    int         d;
    logic [2:0] obs;
    logic [2:0] p;
    logic [2:0] exp;
    logic       do_pop;
    logic       do_push;
    if (n == 0) begin
      q = eq0; u = mused0; d = 4; obs = piece0;
    end else begin
      q = eq1; u = mused1; d = 2; obs = piece1;
    end
    do_pop  = tk && (q.size() > 0);
    do_push = (q.size() < d) || do_pop;
    p = pick(mlfsr, u);
    if (do_pop) begin
      exp = q.pop_front();
      check($sformatf("pop_piece%0d", n), int'(obs), int'(exp));
      check($sformatf("piece_range%0d", n), int'(obs <= 3'd6), 1);
`ifdef PIECEBAG_BAG_EN
      if (n == 0) begin
        bag_seen = bag_seen | (7'b1 << obs);
        pop_cnt++;
        if (pop_cnt % 7 == 0) begin
          check("bag_perm", int'(bag_seen), 'h7F);
          bag_seen = '0;
        end
      end
`endif
    end
    if (do_push) begin
      q.push_back(p);
`ifdef PIECEBAG_BAG_EN
      u = mark(u, p);
`endif
    end
    if (n == 0) begin
      eq0 = q; mused0 = u;
    end else begin
      eq1 = q; mused1 = u;
    end
  endtask

  // Compare every output of both instances against the scoreboard contents.
  task automatic check_outs(input string ctx);
    logic [8:0] ep0;
    logic [2:0] ev0;
    logic [2:0] ep1;
    logic [0:0] ev1;
    ep0 = '0; ev0 = '0; ep1 = '0; ev1 = '0;
    for (int i = 0; i < 3; i++) begin
      if (eq0.size() > i + 1) begin
        ep0[3*i +: 3] = eq0[i+1];
        ev0[i]        = 1'b1;
      end
    end
    if (eq1.size() > 1) begin
      ep1    = eq1[1];
      ev1[0] = 1'b1;
    end
    check({ctx, ".valid0"},   int'(valid0),   int'(eq0.size() > 0));
    check({ctx, ".piece0"},   int'(piece0),   (eq0.size() > 0) ? int'(eq0[0]) : 0);
    check({ctx, ".preview0"}, int'(preview0), int'(ep0));
    check({ctx, ".pvalid0"},  int'(pv0),      int'(ev0));
    check({ctx, ".valid1"},   int'(valid1),   int'(eq1.size() > 0));
    check({ctx, ".piece1"},   int'(piece1),   (eq1.size() > 0) ? int'(eq1[0]) : 0);
    check({ctx, ".preview1"}, int'(preview1), int'(ep1));
    check({ctx, ".pvalid1"},  int'(pv1),      int'(ev1));
  endtask

  task automatic step(input logic tk);
    take = tk;
    model_inst(0, tk);
    model_inst(1, tk);
    mlfsr = {mlfsr[13:0], mlfsr[14] ^ mlfsr[13]};
    @(posedge clk);
    #1;
    check_outs("cyc");
  endtask

  initial begin
    nreset = 1'b0;
    take   = 1'b0;
    model_reset();
    #12;
    check_outs("reset");
    nreset = 1'b1;

    // take on the very first cycle: queue empty, so nothing pops
    step(1'b1);
    // fill: preview_valid walks 001 -> 011 -> 111, then holds
    repeat (4) step(1'b0);
    check("full_pvalid0", int'(pv0), 'b111);
    // sustained pop+push every cycle
    repeat (70) begin
      step(1'b1);
      check("stream_valid0", int'(valid0), 1);
      check("stream_valid1", int'(valid1), 1);
    end
    repeat (30) step(1'($urandom_range(0, 1)));
    repeat (5) step(1'b0);

    // asynchronous reset with a full queue, checked before any clock edge
    #2;
    nreset = 1'b0;
    #1;
    check("arst.valid0",   int'(valid0),   0);
    check("arst.piece0",   int'(piece0),   0);
    check("arst.preview0", int'(preview0), 0);
    check("arst.pvalid0",  int'(pv0),      0);
    check("arst.valid1",   int'(valid1),   0);
    check("arst.preview1", int'(preview1), 0);
    check("arst.pvalid1",  int'(pv1),      0);
    model_reset();
    @(negedge clk);
    nreset = 1'b1;

    // restart from SEED: first pop is a no-op, then 14 pops (two full bags)
    repeat (15) step(1'b1);
    repeat (20) step(1'($urandom_range(0, 1)));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/piecebag.md
# piecebag

Parametrised successor to the single-piece generator: produces a stream of tetromino codes 0..6 using a 7-bag randomiser and holds them in a preview queue of configurable depth. It sits between the game controller and the LFSR source. The controller consumes the head piece with a one-cycle `take` strobe and reads upcoming pieces for the preview display. Unlike the old generator, a new piece is accepted every non-full cycle and no invalid code ever reaches the output.

## Interface
Parameters:
- `PREVIEW_DEPTH`, 3: number of upcoming pieces exposed after the head; legal range 1..6. Queue depth is D = PREVIEW_DEPTH+1.
- `SEED`, 15'h6A5: LFSR seed; must be nonzero.

Ports:
- `clk`  in  1  system clock; one clock domain only.
- `nreset`  in  1  reset; asynchronous, active-low.
- `take`  in  1  pop strobe; acts only when `valid`=1.
- `valid`  out  1  head entry present.
- `piece`  out  3  head piece code, 0..6.
- `preview`  out  PREVIEW_DEPTH×3  `preview[i]` is queue entry i+1.
- `preview_valid`  out  PREVIEW_DEPTH  bit i set when `preview[i]` holds a piece.

## Operation
- LFSR: 15-bit Fibonacci, taps x^15+x^14+1, advances every cycle from `SEED`.
- Candidate selection: r = lfsr[2:0]. Start index s = (r==7) ? 0 : r.
- Selected piece p is the first index with used_mask[p]==0, scanning s, s+1, … mod 7. used_mask is 7 bits.
- Because the mask is never full when sampled, a piece is always found, so selection is deterministic each cycle.
- Push condition: count<D, or (count==D and `take` and `valid`).
- On push: p is written to the tail and used_mask[p] is set.
- If setting that bit would make the mask 7'h7F, the mask clears to 0 in the same cycle instead. This starts a new bag.
- Pop: when `take` and `valid`, the head is removed and entries shift toward the head (or the read pointer advances).
- Simultaneous push and pop: count is unchanged and both take effect.
- `take` with `valid`=0 is ignored, with no side effect.
- Codes 7 are never written to the queue.

## Timing
- Reset (asynchronous, immediate) clears the following:
  - Outputs: `valid`=0, `piece`=0, `preview`=all 0, `preview_valid`=0.
  - Internal state: count=0, used_mask=0, LFSR=`SEED`.
- All outputs are registered. A push at edge k is visible after edge k.
- First rising edge after reset release: push, so `valid`=1.
- `preview_valid` reaches all-ones after D edges with no `take`.
- Steady state with `take` held high: one pop and one push per cycle, and `valid` never drops.
- Pop-to-next-piece latency is 0 cycles: the new head is present right after the popping edge.
- Unfilled preview slots read 0 with their valid bit low.
- Reset mid-operation discards queue and bag contents. Refill restarts from `SEED`.

## Configuration
- `PIECEBAG_BAG_EN` defined: 7-bag behaviour as above. Every aligned group of 7 pushes since reset is a permutation of 0..6.
- Undefined: used_mask logic is removed and p = s directly (plain random, 7 folded onto 0). All other behaviour and timing are identical.

## Structure
- Shared package `tetris_pkg` holds:
  - `piece_t` 3-bit enum (I=0, O, T, S, Z, J, L=6)
  - `NUM_PIECE_TYPES`=7
  - `PIECE_NONE`=3'b111, reserved and never emitted
- One sub-module: the existing `lfsr`, instantiated with `.SEED(SEED)`.
- Selection scan and queue stay in this module.

## Test plan
- Reset release, `take`=0: `valid`=1 after edge 1. With PREVIEW_DEPTH=3, `preview_valid` steps 000→001→011→111 on edges 2..4, then holds.
- Hold `take`=1 for 70 cycles after fill: `valid`=1 every cycle, `piece` is never 7, and the queue order shifts correctly (old `preview[0]` becomes `piece`).
- `PIECEBAG_BAG_EN` defined, 14 pops from reset: pops 1–7 and pops 8–14 are each permutations of {0..6}.
- `take`=1 on the cycle after reset (queue empty): no pop, and `piece`/`preview` are unchanged apart from the normal push.
- Assert `nreset` low mid-stream with a full queue: all outputs go to 0 asynchronously. After release, the sequence repeats the post-reset sequence exactly (same `SEED`).
- PREVIEW_DEPTH=1 build: D=2 with correct full/pop-push-same-cycle behaviour. Without the macro, pieces stay in 0..6 and repeats within 7 are permitted.
